booth_mult_seq: RTL and testbench

// - Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH product, one Booth step per clock.
// - Sits directly upstream of the multiplier overflow detector: drives the 33-bit high slice, the low word
//   and the operand-A-zero flag that the detector consumes; also returns the low word to the ALU/MULTDIV path.

---
 rtl/booth_mult_seq.sv | 104 ++++++++++
 tb/tb_booth_mult_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH, one Booth step per clock.
// Optional macro BOOTH_EARLY_ZERO_EN: a zero operand skips the iterations and completes in one cycle.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic [WIDTH:0]   prod_hi33,
  output logic [WIDTH-1:0] prod_lo32,
  output logic             is_a_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: ctrl_mult is a single-cycle request that is always accepted (it aborts any
  // op in flight); data_resultRDY is a single-cycle valid with no back-pressure, and the
  // result outputs hold their value afterwards until the next ctrl_mult.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [2*WIDTH:0]    p;
  logic [2*WIDTH:0]    p_step;
  logic [2*WIDTH:0]    p_load;
  logic [WIDTH-1:0]    mcand;
  logic [CW-1:0]       cnt;
  logic [WIDTH:0]      hi_ext;
  logic [WIDTH:0]      mc_ext;
  logic [WIDTH:0]      sum;
  logic                early_zero;

`ifdef BOOTH_EARLY_ZERO_EN
  assign early_zero = (data_operandA == '0) || (data_operandB == '0);
`else
  assign early_zero = 1'b0;
`endif

  assign p_load = early_zero ? '0 : {{WIDTH{1'b0}}, data_operandB, 1'b0};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (ctrl_mult) state_nx = early_zero ? DONE : RUN;
  end

  // Add/sub one bit wider than the high half so that mcand = -2^(WIDTH-1) keeps its sign;
  // the extra bit is absorbed by the arithmetic shift.
  always_comb begin
    hi_ext = {p[2*WIDTH], p[2*WIDTH:WIDTH+1]};
    mc_ext = {mcand[WIDTH-1], mcand};
    case (p[1:0])
      2'b01:   sum = hi_ext + mc_ext;
      2'b10:   sum = hi_ext - mc_ext;
      default: sum = hi_ext;
    endcase
    p_step = {sum, p[WIDTH:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      p         <= '0;
      mcand     <= '0;
      cnt       <= '0;
      is_a_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (ctrl_mult) begin
        mcand     <= data_operandA;
        p         <= p_load;
        cnt       <= '0;
        is_a_zero <= (data_operandA == '0);
      end else if (state == RUN) begin
        p   <= p_step;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Product is P[2W:1]; the high slice overlaps the low word by one bit for the overflow check.
  assign data_result    = p[WIDTH:1];
  assign prod_lo32      = p[WIDTH:1];
  assign prod_hi33      = p[2*WIDTH:WIDTH];
  assign data_resultRDY = (state == DONE);
  assign busy           = (state == RUN);
  assign dbg_state      = state;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner cases plus random operands,
// scored against a plain signed-multiply reference through an expected-result queue.
module tb_booth_mult_seq;

  localparam int W  = 32;
  localparam int EW = 2*W + 2;   // {lo word, hi33 slice, is_a_zero}

  logic         clock;
  logic         reset;
  logic         ctrl_mult;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_resultRDY;
  logic [W:0]   prod_hi33;
  logic [W-1:0] prod_lo32;
  logic         is_a_zero;
  logic         busy;
  logic [1:0]   dbg_state;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .prod_hi33      (prod_hi33),
    .prod_lo32      (prod_lo32),
    .is_a_zero      (is_a_zero),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: plain 64-bit signed multiply
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] pr;
    pr = 64'($signed(64'($signed(a))) * $signed(64'($signed(b))));
    return {pr[W-1:0], pr[2*W-1:W-1], (a == '0)};
  endfunction

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BOOTH_EARLY_ZERO_EN
    if (a == '0 || b == '0) return 1;
`endif
    return W + 1;
  endfunction

  // monitor: every RDY pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy: got rdy=1 with no operation outstanding, required rdy=0");
      end else begin
        check("result", {data_result, prod_hi33, is_a_zero}, exp_q.pop_front());
        check("lo_eq_result", EW'(prod_lo32), EW'(data_result));
      end
    end
  end

  // driver: pulse ctrl_mult for one cycle, then scramble operands (they must be ignored)
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // full operation: queue expectation, then bound the wait and check latency
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [EW-1:0] e;
    e = model(a, b);
    exp_q.push_back(e);
    start(a, b);
    n = 1;
    if (exp_latency(a, b) > 1) check({name, "_busy"}, EW'(busy), EW'(1));
    while (!data_resultRDY && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({name, "_latency"}, EW'(n), EW'(exp_latency(a, b)));
    @(negedge clock);
    check({name, "_hold"}, EW'({data_result, busy, data_resultRDY}), EW'({e[EW-1 -: W], 2'b00}));
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_mult     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs",
          EW'({data_result, prod_hi33, is_a_zero}), EW'(0));
    check("reset_ctrl", EW'({data_resultRDY, busy, dbg_state}), EW'(0));
    reset = 1'b0;

    do_op("a3_b5",   32'd3, 32'd5);
    do_op("am7_b6",  32'hFFFF_FFF9, 32'd6);
    do_op("min_min", 32'h8000_0000, 32'h8000_0000);
    do_op("a0_b1234", 32'd0, 32'h1234);
    do_op("a5_b0",   32'd5, 32'd0);
    do_op("min_max", 32'h8000_0000, 32'h7FFF_FFFF);
    do_op("m1_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // abort: a second request mid-run replaces the first, which must never report
    start(32'd2, 32'd2);
    repeat (8) @(negedge clock);
    do_op("abort_restart", 32'd4, 32'hFFFF_FFFD);

    // reset mid-operation: state and outputs clear, and no RDY ever appears
    start(32'd5, 32'd7);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_outputs", EW'({data_result, prod_hi33, is_a_zero}), EW'(0));
    check("midreset_ctrl", EW'({data_resultRDY, busy, dbg_state}), EW'(0));
    repeat (40) @(negedge clock);

    // random operands, biased towards extreme values
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: a = 32'($urandom_range(0, 3));
        default: ;
      endcase
      do_op("random", a, b);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
